// File: rtl/hood_pkg.sv
// Shared range-hood definitions: panel mode encoding used by the mode controller,
// display and smoke-sensor blocks.
package hood_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF       = 3'd0;
  localparam logic [MODE_W-1:0] MODE_STANDBY   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_RUN       = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BOOST     = 3'd3;
  localparam logic [MODE_W-1:0] MODE_CLEAN     = 3'd4;
  localparam logic [MODE_W-1:0] MODE_VIEW_CUM  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_VIEW_GEST = 3'd6;

  function automatic logic is_countdown(input logic [MODE_W-1:0] m);
    return (m == MODE_BOOST) || (m == MODE_CLEAN);
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_sec_tick.sv
// Seconds timebase: free-running 0..CLK_HZ-1 cycle counter, tick on the last
// cycle of each second; clear restarts a full second.
module sec_tick #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood front-panel mode controller: button edge detection, mode FSM,
// boost / self-clean countdowns and LED decode.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned N_SPEEDS  = 3,
  parameter int unsigned BOOST_SEC = 60,
  parameter int unsigned CLEAN_SEC = 180,
  localparam int unsigned SPW      = $clog2(N_SPEEDS + 1),
  localparam int unsigned LW       = N_SPEEDS + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power_on,
  input  logic                menu_btn,
  input  logic [N_SPEEDS-1:0] speed_btn,
  input  logic                clean_btn,
  input  logic                view_cum_btn,
  input  logic                view_gest_btn,
  input  logic                boost_enable,
  output logic [MODE_W-1:0]   mode,
  output logic [SPW-1:0]      speed,
  output logic [LW-1:0]       led,
  output logic                menu_armed,
  output logic [15:0]         remaining_sec,
  output logic                done
);

  logic                menu_q, clean_q, cum_q, gest_q;
  logic [N_SPEEDS-1:0] spd_q;
  logic                menu_p, clean_p, cum_p, gest_p;
  logic [N_SPEEDS-1:0] spd_p;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [SPW-1:0]    speed_q, speed_d;
  logic              armed_q, armed_d;
  logic [15:0]       rem_q, rem_d;
  logic              done_q, done_d;
  logic              ret_q, ret_d;

  logic tick, tick_clear;
  logic hit, ret_now, leave;

  assign menu_p  = menu_btn & ~menu_q;
  assign spd_p   = speed_btn & ~spd_q;
  assign clean_p = clean_btn & ~clean_q;
  assign cum_p   = view_cum_btn & ~cum_q;
  assign gest_p  = view_gest_btn & ~gest_q;

  // Restart the second counter on the edge that enters a countdown.
  assign tick_clear = is_countdown(mode_d) && !is_countdown(mode_q);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    armed_d = armed_q;
    rem_d   = rem_q;
    ret_d   = ret_q;
    done_d  = 1'b0;
    hit     = 1'b0;
    ret_now = 1'b0;
    leave   = 1'b0;

    if (!power_on) begin
      mode_d  = MODE_OFF;
      speed_d = '0;
      armed_d = 1'b0;
      rem_d   = '0;
      ret_d   = 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: mode_d = MODE_STANDBY;

        MODE_STANDBY: begin
          if (armed_q) begin
            for (int unsigned k = 0; k < N_SPEEDS; k++) begin
              if (!hit && spd_p[k] && (k < N_SPEEDS - 1 || boost_enable)) begin
                hit     = 1'b1;
                speed_d = SPW'(k + 1);
                mode_d  = (k == N_SPEEDS - 1) ? MODE_BOOST : MODE_RUN;
              end
            end
            if (!hit && clean_p) begin hit = 1'b1; mode_d = MODE_CLEAN;     end
            if (!hit && cum_p)   begin hit = 1'b1; mode_d = MODE_VIEW_CUM;  end
            if (!hit && gest_p)  begin hit = 1'b1; mode_d = MODE_VIEW_GEST; end
          end
          armed_d = hit ? 1'b0 : (armed_q ^ menu_p);
          if (mode_d == MODE_BOOST) begin
            rem_d = 16'(BOOST_SEC);
            ret_d = 1'b0;
          end
          if (mode_d == MODE_CLEAN) rem_d = 16'(CLEAN_SEC);
        end

        MODE_RUN: begin
          if (menu_p) begin
            mode_d  = MODE_STANDBY;
            speed_d = '0;
          end else begin
            for (int unsigned k = 0; k + 1 < N_SPEEDS; k++) begin
              if (!hit && spd_p[k] && SPW'(k + 1) != speed_q) begin
                hit     = 1'b1;
                speed_d = SPW'(k + 1);
              end
            end
          end
        end

        MODE_BOOST: begin
          // A menu press on the exit cycle still selects the return-to-run path.
          ret_now = ret_q | menu_p;
          ret_d   = ret_now;
          if (!boost_enable) begin
            leave = 1'b1;
          end else if (tick) begin
            if (rem_q == 16'd1) begin
              leave  = 1'b1;
              done_d = 1'b1;
            end else begin
              rem_d = rem_q - 16'd1;
            end
          end
          if (leave) begin
            rem_d = '0;
            ret_d = 1'b0;
            if (ret_now && N_SPEEDS > 1) begin
              mode_d  = MODE_RUN;
              speed_d = SPW'(N_SPEEDS - 1);
            end else begin
              mode_d  = MODE_STANDBY;
              speed_d = '0;
            end
          end
        end

        MODE_CLEAN: begin
          if (tick) begin
            if (rem_q == 16'd1) begin
              rem_d  = '0;
              done_d = 1'b1;
              mode_d = MODE_STANDBY;
            end else begin
              rem_d = rem_q - 16'd1;
            end
          end
        end

        MODE_VIEW_CUM, MODE_VIEW_GEST: begin
          if (menu_p) mode_d = MODE_STANDBY;
        end

        default: begin
          mode_d  = MODE_OFF;
          speed_d = '0;
          armed_d = 1'b0;
          rem_d   = '0;
          ret_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      menu_q  <= 1'b0;
      spd_q   <= '0;
      clean_q <= 1'b0;
      cum_q   <= 1'b0;
      gest_q  <= 1'b0;
      mode_q  <= MODE_OFF;
      speed_q <= '0;
      armed_q <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      menu_q  <= menu_btn;
      spd_q   <= speed_btn;
      clean_q <= clean_btn;
      cum_q   <= view_cum_btn;
      gest_q  <= view_gest_btn;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      armed_q <= armed_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    led = '0;
    case (mode_q)
      MODE_STANDBY:         led = LW'(1);
      MODE_RUN, MODE_BOOST: led = LW'(1) << speed_q;
      MODE_CLEAN:           led = LW'(1) << (N_SPEEDS + 1);
      default:              led = '0;
    endcase
  end

  assign mode          = mode_q;
  assign speed         = speed_q;
  assign menu_armed    = armed_q;
  assign remaining_sec = rem_q;
  assign done          = done_q;

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Parametrised mode controller for the range-hood front panel. It sits between the debounced panel buttons and the fan, LED and display drivers. It generalises the fixed standby/1/2/3/self-clean selector to N_SPEEDS fan levels, and adds the following:
- an internal, exact seconds timebase;
- a boost (top-speed) countdown with selectable return target;
- a self-clean countdown;
- a remaining-seconds output for the display;
- a one-cycle completion pulse.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clk cycles per second
- N_SPEEDS, 3, fan levels 1..N_SPEEDS; level N_SPEEDS is boost
- BOOST_SEC, 60, boost countdown length (1..65535)
- CLEAN_SEC, 180, self-clean countdown length (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- power_on  in  1  machine on (level)
- menu_btn  in  1  menu key, debounced, synchronous level
- speed_btn  in  N_SPEEDS  speed keys, bit k-1 selects level k
- clean_btn  in  1  self-clean key
- view_cum_btn  in  1  show cumulative-time request
- view_gest_btn  in  1  show gesture-time request
- boost_enable  in  1  boost permitted (level)
- mode  out  3  OFF=0, STANDBY=1, RUN=2, BOOST=3, CLEAN=4, VIEW_CUM=5, VIEW_GEST=6
- speed  out  clog2(N_SPEEDS+1)  active fan level, 0 = fan stopped
- led  out  N_SPEEDS+2  one-hot: bit0 standby, bit k level k, bit N_SPEEDS+1 clean; all 0 in OFF and in both VIEW modes
- menu_armed  out  1  menu toggled, awaiting a selection
- remaining_sec  out  16  countdown value in BOOST/CLEAN, else 0
- done  out  1  one-cycle pulse when a countdown expires

## Operation
- All buttons are used as rising edges. The block registers the previous level of each button internally.
- A "press" means the level is 1 this cycle and was 0 last cycle.

State transitions:
- **OFF**: when power_on goes to 1, the next cycle enters STANDBY.
- **Any state, power_on=0**: next cycle enters OFF with every output at its reset value.
- **STANDBY**:
  - A menu press toggles menu_armed.
  - While menu_armed=1, the first qualifying press wins, in this priority order: speed_btn in ascending index, then clean, then view_cum, then view_gest.
  - Level k<N_SPEEDS goes to RUN with speed=k.
  - Level N_SPEEDS goes to BOOST, but only if boost_enable=1; otherwise that press is ignored.
  - clean goes to CLEAN; view_cum and view_gest go to their VIEW states.
  - Every transition out of STANDBY clears menu_armed.
- **RUN**:
  - A menu press goes to STANDBY; it has priority over speed presses in the same cycle.
  - A press on a different non-boost level changes speed directly.
  - A boost press is ignored; boost is entered only from STANDBY.
- **BOOST** (speed=N_SPEEDS):
  - remaining_sec loads BOOST_SEC on entry.
  - A menu press sets return_latch; return_latch cannot be cleared until exit.
  - At expiry, go to RUN speed N_SPEEDS-1 if return_latch=1, else go to STANDBY. If N_SPEEDS=1, always go to STANDBY.
  - If boost_enable drops to 0, exit immediately using the same rule, with no done pulse.
- **CLEAN** (speed=0):
  - remaining_sec loads CLEAN_SEC on entry. At expiry, go to STANDBY.
  - All buttons are ignored during the countdown.
- **VIEW_CUM / VIEW_GEST** (speed=0): a menu press returns to STANDBY.

## Timing
Reset values:
- mode=OFF, speed=0, led=0, menu_armed=0, remaining_sec=0, done=0.
- Tick counter, return_latch and edge registers all 0.

Latency:
- A button edge changes all outputs on the clock edge after the sampled press (1 cycle).

Timebase:
- A cycle counter runs 0..CLK_HZ-1 and raises tick when it equals CLK_HZ-1.
- The counter is cleared on every entry to BOOST or CLEAN, so the first second is a full CLK_HZ cycles.

Countdown:
- remaining_sec decrements on each tick.
- On the tick where remaining_sec==1, the block:
  - sets remaining_sec=0;
  - pulses done;
  - takes the exit transition in the same cycle.
- A countdown of N seconds therefore lasts exactly N*CLK_HZ cycles from the entry edge.

Boundary conditions:
- **Simultaneous menu press and expiry in BOOST**: the press counts toward return_latch.
- **power_on falling mid-countdown**: abort with no done pulse.
- **Asynchronous reset mid-countdown**: all registers go to their reset values immediately.

## Structure
- Shared package hood_pkg holds the mode encoding constants (OFF..VIEW_GEST) and the 3-bit mode width. The display and smoke-sensor blocks use the same package.
- Sub-module sec_tick (parameter CLK_HZ; ports clk, rst, clear, tick) provides the timebase.
- Edge detection and the FSM live in hood_mode_ctrl.

## Test plan
All scenarios use CLK_HZ=10, N_SPEEDS=3, BOOST_SEC=6, CLEAN_SEC=10.
- **Power-up and RUN selection**: reset, power_on=1, menu press, speed_btn[0] press -> mode=RUN, speed=1, led=5'b00010, menu_armed=0.
- **Speed change and exit from RUN**: from RUN speed 1, speed_btn[1] press -> speed=2. Then a menu press together with speed_btn[0] -> STANDBY, led=5'b00001.
- **Boost without menu**: boost_enable=1, menu, speed_btn[2] -> BOOST, remaining_sec=6. After 60 cycles -> done pulse for 1 cycle, STANDBY, remaining_sec=0.
- **Boost return paths**:
  - Same as above plus a menu press at cycle 25 -> at cycle 60, RUN speed=2.
  - A separate run with boost_enable dropped at cycle 30 -> immediate exit to STANDBY, no done pulse.
- **Boost lockout and clean**:
  - boost_enable=0 with speed_btn[2] press -> stays in STANDBY with menu_armed=1.
  - Then clean press -> CLEAN, led=5'b10000, done after 100 cycles, then STANDBY.
- **Power and reset aborts**:
  - power_on=0 at cycle 40 of CLEAN -> OFF, led=0, no done.
  - Asynchronous rst pulse during BOOST -> all outputs reset within the same cycle.
